// File: rtl/toy_lat_mem_if.sv
// Request/response bus for toy_lat_mem: a valid/ready request channel in and a
// valid/ready response channel out. The requester holds the master modport.
interface toy_lat_mem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    req_vld;
   logic                    req_rdy;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic                    req_wr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [DATA_WIDTH/8-1:0] req_strb;
   logic                    rsp_vld;
   logic                    rsp_rdy;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    rsp_wr;
   logic                    rsp_err;

   modport master (
      output req_vld, req_addr, req_wr, req_wdata, req_strb, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_rdata, rsp_wr, rsp_err
   );

   modport slave (
      input  req_vld, req_addr, req_wr, req_wdata, req_strb, rsp_rdy,
      output req_rdy, rsp_vld, rsp_rdata, rsp_wr, rsp_err
   );
endinterface

// File: rtl/toy_lat_mem.sv
// Single-port data memory with configurable read latency, a response FIFO that
// absorbs back-pressure, and an outstanding counter that keeps the FIFO from overflowing.
module toy_lat_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 2,
   parameter int RSP_DEPTH  = 4
) (
   input  logic          clk,
   input  logic          rst,
   toy_lat_mem_if.slave  bus
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

   typedef struct packed {
      logic                  wr;
      logic                  err;
      logic [DATA_WIDTH-1:0] data;
   } rsp_t;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  r_pipeVld [LATENCY];
   rsp_t                  r_pipe    [LATENCY];

   rsp_t                  r_fifo [RSP_DEPTH];
   logic [PTR_W-1:0]      r_wrPtr;
   logic [PTR_W-1:0]      r_rdPtr;
   logic [CNT_W-1:0]      r_fifoCnt;
   logic [CNT_W-1:0]      r_outstanding;

   logic                  w_accept;
   logic                  w_err;
   logic [IDX_W-1:0]      w_idx;
   rsp_t                  w_new;
   logic                  w_fifoEmpty;
   logic                  w_tailVld;
   rsp_t                  w_tail;
   rsp_t                  w_head;
   logic                  w_rspVld;
   rsp_t                  w_rsp;
   logic                  w_rspFire;
   logic                  w_push;
   logic                  w_pop;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Request side: ready depends only on the registered outstanding count,
   // so a requester can never see a combinational path from its own valid.
   assign bus.req_rdy = (r_outstanding < CNT_W'(RSP_DEPTH));
   assign w_accept    = bus.req_vld & bus.req_rdy;
   assign w_err       = (bus.req_addr >= ADDR_WIDTH'(DEPTH));
   assign w_idx       = bus.req_addr[IDX_W-1:0];

   // Build the response for the request being accepted this cycle; reads
   // sample the array now, so a write on the previous edge is already visible.
   always_comb begin
      w_new.wr   = bus.req_wr;
      w_new.err  = w_err;
      w_new.data = '0;
      if (!bus.req_wr && !w_err) begin
         w_new.data = r_mem[w_idx];
      end
   end

   // Byte-masked write into the array; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (!rst && w_accept && bus.req_wr && !w_err) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.req_strb[b]) begin
               r_mem[w_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
         end
      end
   end

   // Fixed-latency shift register carrying {vld, wr, err, data} to the output side.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_pipeVld[i] <= 1'b0;
            r_pipe[i]    <= '0;
         end
      end else begin
         r_pipeVld[0] <= w_accept;
         r_pipe[0]    <= w_new;
         for (int i = 1; i < LATENCY; i++) begin
            r_pipeVld[i] <= r_pipeVld[i-1];
            r_pipe[i]    <= r_pipe[i-1];
         end
      end
   end

   assign w_tailVld   = r_pipeVld[LATENCY-1];
   assign w_tail      = r_pipe[LATENCY-1];
   assign w_fifoEmpty = (r_fifoCnt == '0);
   assign w_head      = r_fifo[r_rdPtr];

   // The pipeline tail bypasses the FIFO only when the FIFO is empty and the
   // consumer takes it this cycle; otherwise it is queued behind older entries.
   assign w_rspVld  = w_fifoEmpty ? w_tailVld : 1'b1;
   assign w_rsp     = w_fifoEmpty ? w_tail : w_head;
   assign w_rspFire = w_rspVld & bus.rsp_rdy;
   assign w_push    = w_tailVld & ~(w_fifoEmpty & bus.rsp_rdy);
   assign w_pop     = ~w_fifoEmpty & bus.rsp_rdy;

   assign bus.rsp_vld   = w_rspVld;
   assign bus.rsp_rdata = w_rspVld ? w_rsp.data : '0;
   assign bus.rsp_wr    = w_rspVld ? w_rsp.wr   : 1'b0;
   assign bus.rsp_err   = w_rspVld ? w_rsp.err  : 1'b0;

   // FIFO storage needs no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wrPtr] <= w_tail;
      end
   end

   // Circular pointers and occupancy; push and pop may coincide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_fifoCnt <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= nextPtr(r_wrPtr);
         end
         if (w_pop) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         case ({w_push, w_pop})
            2'b10:   r_fifoCnt <= r_fifoCnt + 1'b1;
            2'b01:   r_fifoCnt <= r_fifoCnt - 1'b1;
            default: r_fifoCnt <= r_fifoCnt;
         endcase
      end
   end

   // Outstanding covers everything in the pipeline plus the FIFO, which is
   // what guarantees the FIFO has room by the time an entry reaches the tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outstanding <= '0;
      end else begin
         case ({w_accept, w_rspFire})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && w_accept && bus.req_wr) begin
         $display("[DM][WR] %h : %h", bus.req_addr, bus.req_wdata);
      end
   end

   outstandingBound: assert property (@(posedge clk) disable iff (rst)
      r_outstanding <= CNT_W'(RSP_DEPTH));

   noPushWhenFull: assert property (@(posedge clk) disable iff (rst)
      !(w_push && (r_fifoCnt == CNT_W'(RSP_DEPTH)) && !w_pop));

   noUnderflow: assert property (@(posedge clk) disable iff (rst)
      !(w_rspFire && (r_outstanding == '0)));
`endif

endmodule

// File: tb/tb_toy_lat_mem.sv
// Scoreboard bench for toy_lat_mem: the driver queues hand-computed responses at
// accept time and an independent monitor pops and compares on every response handshake.
module tb_toy_lat_mem;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   toy_lat_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   toy_lat_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH      (1024),
      .LATENCY    (2),
      .RSP_DEPTH  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic        wr;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t        sbQ [$];
   logic [31:0] modelMem [int];
   int          vectors     = 0;
   int          miscompares = 0;
   int          acceptCount = 0;
   int          respCount   = 0;
   bit          rndRdy      = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic modelWrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
      logic [31:0] w;
      w = modelMem.exists(int'(addr)) ? modelMem[int'(addr)] : 32'h0;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      end
      modelMem[int'(addr)] = w;
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [31:0] expData, input logic expErr);
      int   n    = 0;
      bit   done = 1'b0;
      exp_t e;
      bus.req_vld   = 1'b1;
      bus.req_wr    = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_strb  = strb;
      while (!done) begin
         @(negedge clk);
         if (bus.req_rdy === 1'b1) begin
            e.wr   = wr;
            e.err  = expErr;
            e.data = (wr || expErr) ? 32'h0 : expData;
            sbQ.push_back(e);
            if (wr && !expErr) modelWrite(addr, wdata, strb);
            acceptCount++;
            done = 1'b1;
         end else begin
            n++;
            if (n >= 500) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL req_accept_timeout: addr %0h never accepted, required within 500 cycles", addr);
               done = 1'b1;
            end
         end
         @(posedge clk);
         #1;
      end
      bus.req_vld = 1'b0;
   endtask

   task automatic applyModel(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb);
      logic [31:0] expData;
      expData = modelMem.exists(int'(addr)) ? modelMem[int'(addr)] : 32'h0;
      applyStimulus(wr, addr, wdata, strb, expData, 1'b0);
   endtask

   task automatic latencyCheck(input logic [31:0] addr, input logic [31:0] expData);
      exp_t e;
      bus.req_vld  = 1'b1;
      bus.req_wr   = 1'b0;
      bus.req_addr = addr;
      bus.req_strb = 4'h0;
      @(negedge clk);
      checkOutput("lat_req_rdy", bus.req_rdy, 1);
      e.wr   = 1'b0;
      e.err  = 1'b0;
      e.data = expData;
      sbQ.push_back(e);
      acceptCount++;
      @(posedge clk);
      #1;
      bus.req_vld = 1'b0;
      checkOutput("lat_vld_after_accept_edge", bus.rsp_vld, 0);
      @(posedge clk);
      #1;
      checkOutput("lat_vld_after_next_edge", bus.rsp_vld, 1);
   endtask

   task automatic waitDrain();
      int n = 0;
      while (sbQ.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      checkOutput("drain_pending", sbQ.size(), 0);
   endtask

   // Monitor: a handshake happens at the next posedge whenever both are high at negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.rsp_vld === 1'b1 && bus.rsp_rdy === 1'b1) begin
            respCount++;
            if (sbQ.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_rsp: got wr=%0b err=%0b rdata=%0h, required no response",
                        bus.rsp_wr, bus.rsp_err, bus.rsp_rdata);
            end else begin
               e = sbQ.pop_front();
               checkOutput("rsp", {bus.rsp_wr, bus.rsp_err, bus.rsp_rdata}, {e.wr, e.err, e.data});
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rndRdy) bus.rsp_rdy = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int respBase;
      bus.req_vld   = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_strb  = '0;
      bus.rsp_rdy   = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req_rdy", bus.req_rdy, 1);
      checkOutput("rst_rsp_vld", bus.rsp_vld, 0);
      checkOutput("rst_rsp_rdata", bus.rsp_rdata, 0);
      checkOutput("rst_rsp_wr", bus.rsp_wr, 0);
      checkOutput("rst_rsp_err", bus.rsp_err, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Write then read, exact read latency, read-after-write on consecutive cycles
      applyStimulus(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'd5, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
      waitDrain();
      latencyCheck(32'd5, 32'hDEADBEEF);
      waitDrain();
      applyStimulus(1'b1, 32'd9, 32'h99999999, 4'hF, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'd9, 32'h0, 4'h0, 32'h99999999, 1'b0);

      // Byte enables, including an all-zero strobe no-op write
      applyStimulus(1'b1, 32'd7, 32'h11223344, 4'hF, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'd7, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'd7, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
      applyStimulus(1'b1, 32'd7, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'd7, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
      waitDrain();

      // Out of range: errors return zero data and leave the aliased words alone
      applyStimulus(1'b1, 32'd1023, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'd0, 32'hCAFE0000, 4'hF, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'd1024, 32'h0, 4'h0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'hFFFFFFFF, 32'h12345678, 4'hF, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'd1024, 32'h55555555, 4'hF, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'd1023, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
      applyStimulus(1'b0, 32'd0, 32'h0, 4'h0, 32'hCAFE0000, 1'b0);
      waitDrain();

      // Back-pressure: only RSP_DEPTH reads get in while the consumer stalls
      base = acceptCount;
      bus.rsp_rdy = 1'b0;
      fork
         begin
            applyStimulus(1'b0, 32'd5, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
            applyStimulus(1'b0, 32'd7, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
            applyStimulus(1'b0, 32'd9, 32'h0, 4'h0, 32'h99999999, 1'b0);
            applyStimulus(1'b0, 32'd0, 32'h0, 4'h0, 32'hCAFE0000, 1'b0);
            applyStimulus(1'b0, 32'd1023, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
            applyStimulus(1'b0, 32'd5, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
         end
      join_none
      repeat (10) @(posedge clk);
      #2;
      checkOutput("bp_accepted", acceptCount - base, 4);
      checkOutput("bp_req_rdy", bus.req_rdy, 0);
      checkOutput("bp_rsp_vld", bus.rsp_vld, 1);
      checkOutput("bp_rsp_hold", bus.rsp_rdata, 32'hDEADBEEF);
      bus.rsp_rdy = 1'b1;
      wait fork;
      waitDrain();
      checkOutput("bp_total", acceptCount - base, 6);

      // Reset mid-flight drops pending responses but keeps memory
      applyStimulus(1'b1, 32'd3, 32'h33333333, 4'hF, 32'h0, 1'b0);
      waitDrain();
      bus.rsp_rdy = 1'b0;
      applyStimulus(1'b0, 32'd3, 32'h0, 4'h0, 32'h33333333, 1'b0);
      applyStimulus(1'b0, 32'd3, 32'h0, 4'h0, 32'h33333333, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("pre_rst_rsp_vld", bus.rsp_vld, 1);
      checkOutput("pre_rst_req_rdy", bus.req_rdy, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_req_rdy", bus.req_rdy, 1);
      checkOutput("mid_rst_rsp_vld", bus.rsp_vld, 0);
      sbQ.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.rsp_rdy = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_rst_rsp_vld", bus.rsp_vld, 0);
      applyStimulus(1'b0, 32'd3, 32'h0, 4'h0, 32'h33333333, 1'b0);
      applyStimulus(1'b0, 32'd7, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
      waitDrain();

      // Streaming with random consumer stalls
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'(16 + i), 32'h10000000 + 32'(i), 4'hF, 32'h0, 1'b0);
      end
      waitDrain();
      base     = acceptCount;
      respBase = respCount;
      rndRdy   = 1'b1;
      for (int i = 0; i < 100; i++) begin
         applyModel(1'($urandom_range(0, 1)), 32'(16 + $urandom_range(0, 7)),
                    $urandom, 4'($urandom_range(0, 15)));
      end
      rndRdy = 1'b0;
      @(posedge clk);
      #2;
      bus.rsp_rdy = 1'b1;
      waitDrain();
      checkOutput("stream_accepts", acceptCount - base, 100);
      checkOutput("stream_responses", respCount - respBase, 100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
